// File: rtl/boid_frame_writer.sv
// Frame write engine for the 1-bit boid framebuffer: clears the whole buffer
// on each frame-end strobe, then plots every boid as a clipped 2x2 block.
module boid_frame_writer #(
   parameter int NUM_BOIDS  = 32,
   parameter int FB_WIDTH   = 320,
   parameter int FB_HEIGHT  = 240,
   parameter int ADDR_WIDTH = 20
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  screenEnd,
   output logic [7:0]            pos_read_index,
   input  logic [8:0]            pos_read_x,
   input  logic [7:0]            pos_read_y,
   output logic [ADDR_WIDTH-1:0] boid_write_address,
   output logic                  boid_write_data,
   output logic                  boid_write_enable,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overrun
);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_WAIT, S_PLOT, S_DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT - 1);
   localparam logic [ADDR_WIDTH-1:0] WIDTH_A   = ADDR_WIDTH'(FB_WIDTH);
   localparam logic [9:0]            WIDTH_X   = 10'(FB_WIDTH);
   localparam logic [8:0]            HEIGHT_Y  = 9'(FB_HEIGHT);
   localparam logic [7:0]            LAST_BOID = 8'(NUM_BOIDS - 1);

   state_t                  state_q, state_d;
   logic                    screen_end_q, screen_end_d;
   logic [ADDR_WIDTH-1:0]   clr_q, clr_d;
   logic [7:0]              idx_q, idx_d;
   logic [1:0]              sub_q, sub_d;
   logic [8:0]              x_q, x_d;
   logic [7:0]              y_q, y_d;
   logic [7:0]              index_q, index_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    data_q, data_d;
   logic                    we_q, we_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    overrun_q, overrun_d;
   logic                    start;
   logic [9:0]              px;
   logic [8:0]              py;

   function automatic logic [ADDR_WIDTH-1:0] pixel_addr(input logic [9:0] xx,
                                                        input logic [8:0] yy);
      return ADDR_WIDTH'(yy) * WIDTH_A + ADDR_WIDTH'(xx);
   endfunction

   always_comb begin
      start        = screenEnd & ~screen_end_q;
      screen_end_d = screenEnd;
      state_d      = state_q;
      clr_d        = clr_q;
      idx_d        = idx_q;
      sub_d        = sub_q;
      x_d          = x_q;
      y_d          = y_q;
      overrun_d    = overrun_q | (start & (state_q != S_IDLE));

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLEAR;
               clr_d   = '0;
            end
         end
         S_CLEAR: begin
            if (clr_q == LAST_ADDR) begin
               state_d = S_FETCH;
               idx_d   = '0;
            end else begin
               clr_d = clr_q + 1'b1;
            end
         end
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            // Position store answers one cycle after the index was presented.
            x_d     = pos_read_x;
            y_d     = pos_read_y;
            sub_d   = '0;
            state_d = S_PLOT;
         end
         S_PLOT: begin
            if (sub_q == 2'd3) begin
               if (idx_q == LAST_BOID) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_FETCH;
               end
            end else begin
               sub_d = sub_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they land in registers.
      px        = {1'b0, x_d} + {9'd0, sub_d[0]};
      py        = {1'b0, y_d} + {8'd0, sub_d[1]};
      index_d   = '0;
      addr_d    = '0;
      data_d    = 1'b0;
      we_d      = 1'b0;
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);

      unique case (state_d)
         S_CLEAR: begin
            we_d   = 1'b1;
            addr_d = clr_d;
         end
         S_FETCH, S_WAIT: index_d = idx_d;
         S_PLOT: begin
            index_d = idx_d;
            data_d  = 1'b1;
            addr_d  = pixel_addr(px, py);
            we_d    = (px < WIDTH_X) && (py < HEIGHT_Y);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         screen_end_q <= 1'b0;
         clr_q        <= '0;
         idx_q        <= '0;
         sub_q        <= '0;
         index_q      <= '0;
         addr_q       <= '0;
         data_q       <= 1'b0;
         we_q         <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         screen_end_q <= screen_end_d;
         clr_q        <= clr_d;
         idx_q        <= idx_d;
         sub_q        <= sub_d;
         index_q      <= index_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         we_q         <= we_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         overrun_q    <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      x_q <= x_d;
      y_q <= y_d;
   end

   assign pos_read_index     = index_q;
   assign boid_write_address = addr_q;
   assign boid_write_data    = data_q;
   assign boid_write_enable  = we_q;
   assign busy               = busy_q;
   assign frame_done         = done_q;
   assign overrun            = overrun_q;

endmodule

// File: tb/tb_boid_frame_writer.sv
// Bench for boid_frame_writer on a reduced 320x16 buffer with 8 boids; a
// queue model of the expected write stream is checked on every cycle.
module tb_boid_frame_writer;

   localparam int W   = 320;
   localparam int H   = 16;
   localparam int NB  = 8;
   localparam int CLR = W * H;
   localparam int AW  = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          screenEnd;
   logic [7:0]    pos_read_index;
   logic [8:0]    pos_read_x;
   logic [7:0]    pos_read_y;
   logic [AW-1:0] boid_write_address;
   logic          boid_write_data;
   logic          boid_write_enable;
   logic          busy;
   logic          frame_done;
   logic          overrun;

   int vectors = 0;
   int miscompares = 0;

   logic [8:0] bx [0:255];
   logic [7:0] by [0:255];

   int exp_a[$];
   int exp_d[$];
   int plot_seen[$];
   int clr_cnt  = 0;
   int done_cnt = 0;
   int cyc      = 0;
   int busy_rise = 0;
   bit busy_prev = 1'b0;
   bit model_on  = 1'b1;

   boid_frame_writer #(
      .NUM_BOIDS(NB), .FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .reset(reset), .screenEnd(screenEnd),
      .pos_read_index(pos_read_index), .pos_read_x(pos_read_x), .pos_read_y(pos_read_y),
      .boid_write_address(boid_write_address), .boid_write_data(boid_write_data),
      .boid_write_enable(boid_write_enable), .busy(busy), .frame_done(frame_done),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Position store with a one-cycle registered read
   always @(posedge clk) begin
      pos_read_x <= bx[pos_read_index];
      pos_read_y <= by[pos_read_index];
   end

   task automatic chk(input string nm, input int act, input int req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   // Expected write stream of one complete frame, straight from the plotting rules
   task automatic build_expect();
      exp_a.delete();
      exp_d.delete();
      for (int a = 0; a < CLR; a++) begin
         exp_a.push_back(a);
         exp_d.push_back(0);
      end
      for (int b = 0; b < NB; b++) begin
         for (int s = 0; s < 4; s++) begin
            int xx;
            int yy;
            xx = int'(bx[b]) + (s % 2);
            yy = int'(by[b]) + (s / 2);
            if (xx < W && yy < H) begin
               exp_a.push_back(yy * W + xx);
               exp_d.push_back(1);
            end
         end
      end
      plot_seen.delete();
      clr_cnt = 0;
   endtask

   always @(negedge clk) begin
      cyc++;
      if (model_on) begin
         if (busy && !busy_prev) busy_rise = cyc;
         if (boid_write_enable) begin
            if (exp_a.size() == 0) begin
               chk("extra_write_addr", int'(boid_write_address), -1);
            end else begin
               int ea;
               int ed;
               ea = exp_a.pop_front();
               ed = exp_d.pop_front();
               chk("write_addr", int'(boid_write_address), ea);
               chk("write_data", int'(boid_write_data), ed);
            end
            if (boid_write_data) plot_seen.push_back(int'(boid_write_address));
            else clr_cnt++;
         end
         if (frame_done) begin
            done_cnt++;
            chk("done_latency", cyc - busy_rise, CLR + 6 * NB);
            chk("done_pending_writes", exp_a.size(), 0);
         end
         if (!busy && busy_prev) chk("busy_length", cyc - busy_rise, CLR + 6 * NB + 1);
      end
      busy_prev = busy;
   end

   task automatic pulse_start(input int n);
      @(negedge clk);
      screenEnd = 1'b1;
      repeat (n) @(negedge clk);
      screenEnd = 1'b0;
   endtask

   task automatic wait_frame();
      int n0;
      n0 = done_cnt;
      for (int i = 0; i < CLR + 6 * NB + 200; i++) begin
         @(negedge clk);
         if (done_cnt > n0) break;
      end
      repeat (20) @(negedge clk);
      chk("frame_count", done_cnt, n0 + 1);
   endtask

   task automatic set_default_boids();
      bx[0] = 9'd10;
      by[0] = 8'd5;
      for (int b = 1; b < 256; b++) begin
         bx[b] = 9'd100;
         by[b] = 8'd10;
      end
   endtask

   initial begin
      reset     = 1'b1;
      screenEnd = 1'b0;
      set_default_boids();

      // Reset held with screenEnd toggling
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         screenEnd = ~screenEnd;
         chk("rst_we", int'(boid_write_enable), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_done", int'(frame_done), 0);
         chk("rst_overrun", int'(overrun), 0);
         chk("rst_addr", int'(boid_write_address), 0);
      end
      screenEnd = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_we", int'(boid_write_enable), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_index", int'(pos_read_index), 0);

      // Frame 1: plot pattern, screenEnd level held for 4 cycles
      build_expect();
      chk("model_p0", exp_a[CLR], 1610);
      chk("model_p1", exp_a[CLR + 1], 1611);
      chk("model_p2", exp_a[CLR + 2], 1930);
      chk("model_p3", exp_a[CLR + 3], 1931);
      chk("model_p4", exp_a[CLR + 4], 3300);
      chk("model_len", exp_a.size(), CLR + 4 * NB);
      pulse_start(4);
      wait_frame();
      chk("clear_writes", clr_cnt, CLR);
      chk("plot_count", plot_seen.size(), 4 * NB);
      if (plot_seen.size() == 4 * NB) begin
         chk("plot_0", plot_seen[0], 1610);
         chk("plot_1", plot_seen[1], 1611);
         chk("plot_2", plot_seen[2], 1930);
         chk("plot_3", plot_seen[3], 1931);
         chk("plot_7", plot_seen[7], 3621);
         chk("plot_last", plot_seen[4 * NB - 1], 3621);
      end
      chk("no_overrun", int'(overrun), 0);

      // Frame 2: clipping at the corner, fully off-screen, bottom edge; overrun during CLEAR
      bx[0] = 9'd319; by[0] = 8'd15;
      bx[1] = 9'd400; by[1] = 8'd250;
      bx[2] = 9'd50;  by[2] = 8'd15;
      for (int b = 3; b < NB; b++) begin
         bx[b] = 9'd0;
         by[b] = 8'd0;
      end
      build_expect();
      chk("model_clip0", exp_a[CLR], 5119);
      chk("model_clip1", exp_a[CLR + 1], 4850);
      chk("model_clip_len", exp_a.size(), CLR + 23);
      pulse_start(1);
      repeat (100) @(negedge clk);
      chk("overrun_before", int'(overrun), 0);
      pulse_start(2);
      repeat (2) @(negedge clk);
      chk("overrun_set", int'(overrun), 1);
      chk("busy_in_clear", int'(busy), 1);
      wait_frame();
      chk("plot_count_clip", plot_seen.size(), 23);
      if (plot_seen.size() == 23) begin
         chk("clip_corner", plot_seen[0], 5119);
         chk("clip_edge", plot_seen[1], 4850);
         chk("clip_edge2", plot_seen[2], 4851);
         chk("clip_tail", plot_seen[22], 321);
      end
      chk("overrun_sticky", int'(overrun), 1);

      // Frame 3: reset asserted mid-PLOT
      set_default_boids();
      build_expect();
      pulse_start(1);
      for (int i = 0; i < CLR + 100; i++) begin
         @(posedge clk);
         if (plot_seen.size() > 0) break;
      end
      chk("abort_reached_plot", int'(plot_seen.size() > 0), 1);
      #1;
      reset    = 1'b1;
      model_on = 1'b0;
      @(negedge clk);
      chk("abort_we_pre", int'(boid_write_enable), 1);
      @(negedge clk);
      chk("abort_we", int'(boid_write_enable), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(frame_done), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_overrun_clear", int'(overrun), 0);
      chk("abort_idle", int'(busy), 0);

      // Frame 4: full frame after abort restarts at clear address 0
      build_expect();
      model_on = 1'b1;
      pulse_start(1);
      wait_frame();
      chk("restart_clear", clr_cnt, CLR);
      chk("restart_plot", plot_seen.size(), 4 * NB);
      chk("restart_overrun", int'(overrun), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
